riscv_divmod_unit: RTL and testbench
====================================

// Module: riscv_divmod_unit
// PURPOSE
//   Iterative signed divide/modulo unit for the execute stage. It consumes operands and the
//   isDiv/isMod control bits decoded for DIV/MOD instructions.
//   It returns the quotient or remainder plus the destination tag to the mem/writeback path.
//   busy stalls fetch/decode while an op is in flight, because DIV/MOD are not single-cycle.
// PARAMETERS
//   DATA_WIDTH   32  operand/result width (= INSTR_WIDTH)
//   TAG_WIDTH     4  destination register tag width (= ADDR_WIDTH)
// PORTS
//   clk         in   1           single clock, rising edge
//   rst_n       in   1           asynchronous, active-low reset
//   flush       in   1           sync kill (branch redirect); drop any in-flight op
//   in_valid    in   1           op request
//   in_ready    out  1           unit can accept (state IDLE)
//   in_is_mod   in   1           1: return remainder (isMod), 0: quotient (isDiv)
//   in_dividend in   DATA_WIDTH  signed operand A (rs1)
//   in_divisor  in   DATA_WIDTH  signed operand B (rs2 or immediate)
//   in_rd       in   TAG_WIDTH   destination register tag
//   out_valid   out  1           result available
//   out_ready   in   1           consumer takes result
//   out_result  out  DATA_WIDTH  quotient or remainder
//   out_rd      out  TAG_WIDTH   tag of the result
//   busy        out  1           state != IDLE; pipeline stall request
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, out_valid=0, out_result=0, out_rd=0, busy=0, counters 0.
//   Accept: in_valid & in_ready at edge T0. Operands, op and tag are latched.
//     Magnitudes and result signs are captured at T0.
//   States: IDLE -> CALC (divisor!=0) | DONE (divisor==0); CALC -> FIX after 32 iterations;
//     FIX -> DONE; DONE -> IDLE when out_ready.
//   CALC: radix-2 restoring, 1 quotient bit/cycle; 6-bit iteration counter 0..31.
//   FIX: apply signs; out_valid=1 from edge T33 (latency 34 clocks accept->valid).
//   Rounding: truncate toward zero; remainder takes sign of dividend (C semantics).
//   Div by zero: DONE at T0 (valid after 1 clock); quotient=all ones, remainder=dividend.
//   Overflow MIN_INT / -1: quotient=MIN_INT (0x8000_0000), remainder=0; no trap.
//   DONE: out_result/out_rd/out_valid held stable until out_ready=1.
//     out_valid drops the edge after the handshake.
//   in_ready=1 only in IDLE. There is no accept in the same cycle as the DONE handshake.
//     The next op is accepted one cycle later, at earliest.
//   flush: any state -> IDLE at next edge; out_valid=0. flush has priority over in_valid
//     (no accept) and over out_ready (the handshake is ignored).
//   Inputs are ignored while not IDLE; changing them mid-op has no effect.
//   Async reset mid-operation: immediate IDLE; the partial result is discarded.
//   busy = (state != IDLE) combinationally; it includes DONE while waiting for out_ready.
// STRUCTURE
//   riscv_params_pkg additions:
//     typedef enum logic [1:0] {DM_IDLE, DM_CALC, DM_FIX, DM_DONE} divmod_state_e;
//     parameter DIV_ITERS = INSTR_WIDTH;
//     parameter DIVMOD_LATENCY = DIV_ITERS + 2.
//   Single module; no sub-module needed (FSM + shift/subtract datapath, ~200 lines).
//   Width rules: partial remainder DATA_WIDTH+1 bits for the subtract borrow; magnitudes unsigned.
// TESTING
//   1. DIV 100/7 -> 14 with out_valid exactly 34 clocks after accept; MOD 100/7 -> 2; out_rd echoes in_rd=5.
//   2. Signs: -100/7 -> -14, mod -2; 100/-7 -> -14, mod 2; -100/-7 -> 14, mod -2.
//   3. Edge values: x/0 (x=0x1234) -> 0xFFFF_FFFF, mod 0x1234, valid after 1 clock.
//      0x8000_0000/-1 -> 0x8000_0000, mod 0. 0/5 -> 0.
//   4. Backpressure: out_ready=0 for 10 cycles -> result and out_rd held, in_ready=0, busy=1.
//      out_ready=1 -> IDLE next edge; a new in_valid is accepted one cycle later.
//   5. flush at CALC iteration 12, with in_valid=1 in that same cycle -> no accept, IDLE next edge.
//      The following op 9/3 returns 3 with no stale data.
//   6. rst_n low mid-CALC -> all outputs 0 immediately (async); after release, 8/3 returns 2.

Source files
------------

// File: rtl/riscv_divmod_unit_pkg.sv
// Shared types and constants for the iterative signed divide/modulo unit.
//   divmod_state_e  : FSM encoding of the divide unit
//   DIV_ITERS       : quotient bits produced, one per CALC cycle
//   DIVMOD_LATENCY  : accept-to-valid latency in clocks for a non-zero divisor
package riscv_divmod_unit_pkg;

    localparam int unsigned INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_CALC,
        DM_FIX,
        DM_DONE
    } divmod_state_e;

    localparam int unsigned DIV_ITERS      = INSTR_WIDTH;
    localparam int unsigned DIVMOD_LATENCY = DIV_ITERS + 2;

endpackage

// File: rtl/riscv_divmod_unit_if.sv
// Request/response bundle between the execute stage and the divide/modulo unit.
//   master : issuing pipeline (drives request and out_ready)
//   slave  : divide/modulo unit (drives in_ready, result, tag, busy)
interface riscv_divmod_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_is_mod;
    logic [DATA_WIDTH-1:0] in_dividend;
    logic [DATA_WIDTH-1:0] in_divisor;
    logic [TAG_WIDTH-1:0]  in_rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [TAG_WIDTH-1:0]  out_rd;
    logic                  busy;

    modport master (
        output in_valid, in_is_mod, in_dividend, in_divisor, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, busy
    );

    modport slave (
        input  in_valid, in_is_mod, in_dividend, in_divisor, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, busy
    );
endinterface

// File: rtl/riscv_divmod_unit.sv
// Iterative signed divide/modulo unit (radix-2 restoring, one quotient bit per clock).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous kill of any in-flight or pending result
//   bus    : slave side of riscv_divmod_unit_if (request, result, busy stall)
// Truncates toward zero; remainder carries the dividend's sign. Divide by zero
// returns all ones / the dividend after one clock. MIN_INT / -1 wraps to MIN_INT.
module riscv_divmod_unit
    import riscv_divmod_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    riscv_divmod_unit_if.slave   bus
);

    localparam logic [5:0] LAST_ITER = 6'(DATA_WIDTH - 1);

    divmod_state_e         state;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] dvs;
    logic [5:0]            iter;
    logic                  neg_q;
    logic                  neg_r;
    logic                  is_mod;
    logic [TAG_WIDTH-1:0]  rd_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] result_q;

    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;

    always_comb begin
        a_neg   = bus.in_dividend[DATA_WIDTH-1];
        b_neg   = bus.in_divisor[DATA_WIDTH-1];
        // |MIN_INT| is representable as an unsigned magnitude
        a_mag   = a_neg ? -bus.in_dividend : bus.in_dividend;
        b_mag   = b_neg ? -bus.in_divisor  : bus.in_divisor;
        // Next dividend bit enters the partial remainder; the extra top bit
        // of trial is the borrow that decides restore vs. keep.
        shifted = {rem, quo[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DM_IDLE;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            iter     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_mod   <= 1'b0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state   <= DM_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                DM_IDLE: begin
                    if (bus.in_valid) begin
                        is_mod <= bus.in_is_mod;
                        rd_q   <= bus.in_rd;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dvs    <= b_mag;
                        quo    <= a_mag;
                        rem    <= '0;
                        iter   <= '0;
                        if (bus.in_divisor == '0) begin
                            result_q <= bus.in_is_mod ? bus.in_dividend : '1;
                            valid_q  <= 1'b1;
                            state    <= DM_DONE;
                        end else begin
                            state <= DM_CALC;
                        end
                    end
                end
                DM_CALC: begin
                    if (trial[DATA_WIDTH]) begin
                        rem <= shifted[DATA_WIDTH-1:0];
                        quo <= {quo[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[DATA_WIDTH-1:0];
                        quo <= {quo[DATA_WIDTH-2:0], 1'b1};
                    end
                    iter <= iter + 6'd1;
                    if (iter == LAST_ITER) begin
                        state <= DM_FIX;
                    end
                end
                DM_FIX: begin
                    if (is_mod) begin
                        result_q <= neg_r ? -rem : rem;
                    end else begin
                        result_q <= neg_q ? -quo : quo;
                    end
                    valid_q <= 1'b1;
                    state   <= DM_DONE;
                end
                DM_DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= DM_IDLE;
                    end
                end
                default: state <= DM_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == DM_IDLE);
    assign bus.busy       = (state != DM_IDLE);
    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign bus.out_rd     = rd_q;

endmodule

// File: tb/tb_riscv_divmod_unit.sv
// Directed self-checking bench for riscv_divmod_unit.
module tb_riscv_divmod_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    riscv_divmod_unit_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    riscv_divmod_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single clock; returns just after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic m, input logic [3:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        bus.in_is_mod   = m;
        bus.in_rd       = rd;
        tick;
        bus.in_valid    = 1'b0;
    endtask

    // lat counts clocks with the accept clock as 1; capped at 100.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            tick;
            lat++;
        end
    endtask

    task automatic release_result;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic [3:0] rd,
                          output logic [31:0] res, output logic [3:0] rdo,
                          output int lat);
        start_op(a, b, m, rd);
        wait_valid(lat);
        res = bus.out_result;
        rdo = bus.out_rd;
        release_result;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b busy=%b ready=%b expected 0 0 1",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
        checks++;
        if (bus.out_result !== 32'h0 || bus.out_rd !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: got result=%h rd=%h expected 0 0",
                     bus.out_result, bus.out_rd);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        logic [31:0] res;
        logic [3:0]  rdo;
        int          lat;
        run_op(32'd100, 32'd7, 1'b0, 4'd5, res, rdo, lat);
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL div_latency: got %0d expected 34", lat);
        end
        checks++;
        if (res !== 32'd14) begin
            errors++;
            $display("FAIL div_100_7: got %h expected %h", res, 32'd14);
        end
        checks++;
        if (rdo !== 4'd5) begin
            errors++;
            $display("FAIL div_rd: got %h expected 5", rdo);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: got valid=%b busy=%b expected 0 0",
                     bus.out_valid, bus.busy);
        end
        run_op(32'd100, 32'd7, 1'b1, 4'd5, res, rdo, lat);
        checks++;
        if (res !== 32'd2 || lat !== 34) begin
            errors++;
            $display("FAIL mod_100_7: got %h lat %0d expected 2 lat 34", res, lat);
        end
    endtask

    task automatic test_signs;
        logic [31:0] a_v [6] = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100, 32'd100,
                                 32'hFFFF_FF9C, 32'hFFFF_FF9C};
        logic [31:0] b_v [6] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic        m_v [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        // -14, -2, -14, 2, 14, -2
        logic [31:0] e_v [6] = '{32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'd2,
                                 32'd14, 32'hFFFF_FFFE};
        logic [31:0] res;
        logic [3:0]  rdo;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(a_v[i], b_v[i], m_v[i], 4'(i + 1), res, rdo, lat);
            checks++;
            if (res !== e_v[i] || rdo !== 4'(i + 1)) begin
                errors++;
                $display("FAIL signs_%0d: got %h rd %h expected %h rd %h",
                         i, res, rdo, e_v[i], 4'(i + 1));
            end
        end
    endtask

    task automatic test_edges;
        logic [31:0] res;
        logic [3:0]  rdo;
        int          lat;
        run_op(32'h1234, 32'h0, 1'b0, 4'd3, res, rdo, lat);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 1) begin
            errors++;
            $display("FAIL div_zero_q: got %h lat %0d expected ffffffff lat 1", res, lat);
        end
        run_op(32'h1234, 32'h0, 1'b1, 4'd4, res, rdo, lat);
        checks++;
        if (res !== 32'h1234 || lat !== 1 || rdo !== 4'd4) begin
            errors++;
            $display("FAIL div_zero_r: got %h lat %0d rd %h expected 1234 lat 1 rd 4",
                     res, lat, rdo);
        end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd6, res, rdo, lat);
        checks++;
        if (res !== 32'h8000_0000) begin
            errors++;
            $display("FAIL ovf_q: got %h expected 80000000", res);
        end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd6, res, rdo, lat);
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL ovf_r: got %h expected 0", res);
        end
        run_op(32'd0, 32'd5, 1'b0, 4'd7, res, rdo, lat);
        checks++;
        if (res !== 32'h0 || lat !== 34) begin
            errors++;
            $display("FAIL zero_div5: got %h lat %0d expected 0 lat 34", res, lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        start_op(32'd200, 32'd9, 1'b0, 4'd3);
        wait_valid(lat);
        // Competing request held throughout the stall; must not be taken early.
        bus.in_valid    = 1'b1;
        bus.in_dividend = 32'd50;
        bus.in_divisor  = 32'd5;
        bus.in_is_mod   = 1'b0;
        bus.in_rd       = 4'd9;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd22 || bus.out_rd !== 4'd3 ||
                bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d: got v=%b res=%h rd=%h rdy=%b busy=%b expected 1 16 3 0 1",
                         i, bus.out_valid, bus.out_result, bus.out_rd, bus.in_ready, bus.busy);
            end
            tick;
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake_idle: got v=%b rdy=%b busy=%b expected 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        tick;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL next_accept: got busy=%b expected 1", bus.busy);
        end
        wait_valid(lat);
        checks++;
        if (bus.out_result !== 32'd10 || bus.out_rd !== 4'd9 || lat !== 34) begin
            errors++;
            $display("FAIL next_result: got %h rd %h lat %0d expected a rd 9 lat 34",
                     bus.out_result, bus.out_rd, lat);
        end
        release_result;
    endtask

    task automatic test_flush;
        logic [31:0] res;
        logic [3:0]  rdo;
        int          lat;
        start_op(32'd1000, 32'd3, 1'b0, 4'd2);
        repeat (12) tick;
        flush           = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_dividend = 32'd77;
        bus.in_divisor  = 32'd7;
        bus.in_is_mod   = 1'b0;
        bus.in_rd       = 4'd7;
        tick;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: got busy=%b v=%b rdy=%b expected 0 0 1",
                     bus.busy, bus.out_valid, bus.in_ready);
        end
        tick;
        run_op(32'd9, 32'd3, 1'b0, 4'd11, res, rdo, lat);
        checks++;
        if (res !== 32'd3 || rdo !== 4'd11 || lat !== 34) begin
            errors++;
            $display("FAIL after_flush: got %h rd %h lat %0d expected 3 rd b lat 34",
                     res, rdo, lat);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] res;
        logic [3:0]  rdo;
        int          lat;
        start_op(32'd1000, 32'd7, 1'b1, 4'd6);
        repeat (5) tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_result !== 32'h0 || bus.out_rd !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b busy=%b res=%h rd=%h expected 0 0 0 0",
                     bus.out_valid, bus.busy, bus.out_result, bus.out_rd);
        end
        tick;
        #2 rst_n = 1'b1;
        tick;
        run_op(32'd8, 32'd3, 1'b0, 4'd4, res, rdo, lat);
        checks++;
        if (res !== 32'd2 || rdo !== 4'd4) begin
            errors++;
            $display("FAIL after_reset: got %h rd %h expected 2 rd 4", res, rdo);
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_is_mod   = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.in_rd       = '0;
        bus.out_ready   = 1'b0;
        test_reset;
        test_basic;
        test_signs;
        test_edges;
        test_back_to_back;
        test_flush;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
